// File: rtl/switch_conf_control_mt.sv
// rtl/switch_conf_control_mt.sv - multi-thread switch configuration sequencer
module switch_conf_control_mt #(
    parameter int SWITCH_NUMBER = 0,
    parameter int STAGE         = 1,
    parameter int NUM_THREADS   = 7,
    parameter int CONF_WIDTH    = 2,
    parameter int PC_WIDTH      = 1,
    parameter int BUS_WIDTH     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_pc_net,
    input  logic [BUS_WIDTH-1:0]   conf_bus_in,
    output logic [CONF_WIDTH-1:0]  swicth_conf_out,
    output logic [NUM_THREADS-1:0] thread_done,
    output logic                   conf_busy
);

    localparam int TID_W     = (NUM_THREADS > 2) ? $clog2(NUM_THREADS) : 1;
    localparam int AW        = TID_W + PC_WIDTH;
    localparam int MEM_DEPTH = NUM_THREADS << PC_WIDTH;
    localparam int NPIPE     = STAGE + 3;
    localparam int DW        = (CONF_WIDTH > PC_WIDTH) ? CONF_WIDTH : PC_WIDTH;

    localparam logic [3:0] OP_WR      = 4'd1;
    localparam logic [3:0] OP_MAX     = 4'd2;
    localparam logic [3:0] OP_LOOP    = 4'd3;
    localparam logic [3:0] OP_MODE    = 4'd4;
    localparam logic [3:0] OP_RESTART = 4'd5;

    localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);

    logic                  cmd_valid_q, cmd_valid_d;
    logic [3:0]            cmd_op_q, cmd_op_d;
    logic [TID_W-1:0]      cmd_tid_q, cmd_tid_d;
    logic [PC_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DW-1:0]         cmd_data_q, cmd_data_d;
    logic [TID_W-1:0]      cnt_q, cnt_d;
    logic [CONF_WIDTH-1:0] rd_q, rd_d;
    logic [CONF_WIDTH-1:0] pipe_q [NPIPE];
    logic [CONF_WIDTH-1:0] pipe_d [NPIPE];
    logic [PC_WIDTH-1:0]   pc_q   [NUM_THREADS];
    logic [PC_WIDTH-1:0]   pc_d   [NUM_THREADS];
    logic [PC_WIDTH-1:0]   max_q  [NUM_THREADS];
    logic [PC_WIDTH-1:0]   max_d  [NUM_THREADS];
    logic [PC_WIDTH-1:0]   loop_q [NUM_THREADS];
    logic [PC_WIDTH-1:0]   loop_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] mode_q, mode_d;
    logic [NUM_THREADS-1:0] done_q, done_d;

    logic [CONF_WIDTH-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         wr_addr;
    logic                  unused_bus;

    assign unused_bus = ^conf_bus_in;
    assign rd_addr    = {cnt_q, pc_q[cnt_q]};
    assign wr_addr    = {cmd_tid_q, cmd_addr_q};

    // Stage C: qualify and truncate the bus command
    always_comb begin
        cmd_op_d    = conf_bus_in[3:0];
        cmd_tid_d   = conf_bus_in[16 +: TID_W];
        cmd_addr_d  = conf_bus_in[24 +: PC_WIDTH];
        cmd_data_d  = conf_bus_in[40 +: DW];
        cmd_valid_d = (cmd_op_d >= OP_WR) && (cmd_op_d <= OP_RESTART)
                   && (conf_bus_in[15:4] == 12'(SWITCH_NUMBER))
                   && ((32'(conf_bus_in[23:16]) < 32'(NUM_THREADS)) || (cmd_op_d == OP_RESTART));
    end

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        for (int k = 0; k < NPIPE; k++) pipe_d[k] = pipe_q[k];
        if (en_pc_net) begin
            cnt_d     = (cnt_q == LAST_TID) ? '0 : cnt_q + TID_W'(1);
            rd_d      = mem[rd_addr];
            pipe_d[0] = rd_q;
            for (int k = 1; k < NPIPE; k++) pipe_d[k] = pipe_q[k-1];
        end
    end

    // Command effects are applied after the PC advance so they take priority
    always_comb begin
        mode_d = mode_q;
        done_d = done_q;
        for (int i = 0; i < NUM_THREADS; i++) begin
            pc_d[i]   = pc_q[i];
            max_d[i]  = max_q[i];
            loop_d[i] = loop_q[i];
            if (en_pc_net && (cnt_q == TID_W'(i))) begin
                if (pc_q[i] != max_q[i]) begin
                    pc_d[i] = pc_q[i] + PC_WIDTH'(1);
                end else if (!mode_q[i]) begin
                    pc_d[i] = loop_q[i];
                end else begin
                    done_d[i] = 1'b1;
                end
            end
            if (cmd_valid_q) begin
                if (cmd_op_q == OP_RESTART) begin
                    pc_d[i]   = '0;
                    done_d[i] = 1'b0;
                end else if ((cmd_tid_q == TID_W'(i)) && (cmd_op_q != OP_WR)) begin
                    pc_d[i]   = '0;
                    done_d[i] = 1'b0;
                    if (cmd_op_q == OP_MAX)  max_d[i]  = cmd_data_q[PC_WIDTH-1:0];
                    if (cmd_op_q == OP_LOOP) loop_d[i] = cmd_data_q[PC_WIDTH-1:0];
                    if (cmd_op_q == OP_MODE) mode_d[i] = cmd_data_q[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_valid_q && (cmd_op_q == OP_WR)) begin
            mem[wr_addr] <= cmd_data_q[CONF_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_tid_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            mode_q      <= '0;
            done_q      <= '0;
            for (int k = 0; k < NPIPE; k++) pipe_q[k] <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i]   <= '0;
                max_q[i]  <= '0;
                loop_q[i] <= '0;
            end
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_tid_q   <= cmd_tid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            for (int k = 0; k < NPIPE; k++) pipe_q[k] <= pipe_d[k];
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i]   <= pc_d[i];
                max_q[i]  <= max_d[i];
                loop_q[i] <= loop_d[i];
            end
        end
    end

    assign swicth_conf_out = pipe_q[NPIPE-1];
    assign thread_done     = done_q;
    assign conf_busy       = cmd_valid_q;

endmodule

// File: tb/tb_switch_conf_control_mt.sv
// tb/tb_switch_conf_control_mt.sv - directed bench for switch_conf_control_mt
module tb_switch_conf_control_mt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, en_g;
    logic [63:0] bus, bus_g;
    logic [1:0]  out;
    logic [6:0]  done;
    logic        busy;
    logic [7:0]  out_g;
    logic [4:0]  done_g;
    logic        busy_g;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          step;
        int          kind;
        logic [31:0] exp;
    } tv_t;

    typedef struct {
        logic [63:0] bus;
        logic [31:0] busy;
        logic [31:0] done;
        logic [31:0] out;
    } fv_t;

    tv_t dtab [5];
    tv_t otab [11];
    tv_t gtab [11];
    fv_t ftab [8];
    int  gpc  [11];

    always #5 clk = ~clk;

    switch_conf_control_mt #(
        .SWITCH_NUMBER(0), .STAGE(1), .NUM_THREADS(7),
        .CONF_WIDTH(2), .PC_WIDTH(1), .BUS_WIDTH(64)
    ) u_dut (
        .clk(clk), .rst(rst), .en_pc_net(en), .conf_bus_in(bus),
        .swicth_conf_out(out), .thread_done(done), .conf_busy(busy)
    );

    switch_conf_control_mt #(
        .SWITCH_NUMBER(2), .STAGE(1), .NUM_THREADS(5),
        .CONF_WIDTH(8), .PC_WIDTH(3), .BUS_WIDTH(64)
    ) u_gen (
        .clk(clk), .rst(rst), .en_pc_net(en_g), .conf_bus_in(bus_g),
        .swicth_conf_out(out_g), .thread_done(done_g), .conf_busy(busy_g)
    );

    function automatic logic [63:0] mk(input int o, input int g, input int t, input int a, input int d);
        logic [31:0] ov, gv, tv, av, dv;
        ov = o; gv = g; tv = t; av = a; dv = d;
        return {dv[23:0], av[15:0], tv[7:0], gv[11:0], ov[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [63:0] w);
        bus = w;
        step();
        chk("cmd_busy_on", 32'(busy), 1);
        bus = '0;
        step();
        chk("cmd_busy_off", 32'(busy), 0);
    endtask

    task automatic cmd_g(input logic [63:0] w);
        bus_g = w;
        step();
        chk("gen_busy_on", 32'(busy_g), 1);
        bus_g = '0;
        step();
        chk("gen_busy_off", 32'(busy_g), 0);
    endtask

    task automatic run_table(input string name, input tv_t tab [11], input int n, input int steps);
        for (int s = 1; s <= steps; s++) begin
            step();
            for (int j = 0; j < n; j++) begin
                if (tab[j].step == s) begin
                    if (tab[j].kind == 0) chk({name, "_out"}, 32'(out), tab[j].exp);
                    else                  chk({name, "_done"}, 32'(done), tab[j].exp);
                end
            end
            if (name == "oneshot" && s == 22) bus = mk(5, 0, 7, 0, 0);
            if (name == "oneshot" && s == 23) begin
                chk("restart_busy", 32'(busy), 1);
                bus = '0;
            end
            if (name == "oneshot" && s == 24) chk("restart_busy_off", 32'(busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv_t dt [11];

        dtab[0] = '{4, 0, 0};  dtab[1] = '{5, 0, 1};  dtab[2] = '{12, 0, 2};
        dtab[3] = '{19, 0, 1}; dtab[4] = '{26, 0, 2};
        otab[0] = '{8, 0, 3};  otab[1] = '{15, 0, 2}; otab[2] = '{22, 0, 2};
        otab[3] = '{29, 0, 3}; otab[4] = '{36, 0, 2}; otab[5] = '{10, 1, 0};
        otab[6] = '{11, 1, 8}; otab[7] = '{22, 1, 8}; otab[8] = '{24, 1, 0};
        otab[9] = '{31, 1, 0}; otab[10] = '{32, 1, 8};
        ftab[0] = '{mk(2, 1, 3, 0, 1), 0, 8, 2};
        ftab[1] = '{mk(4, 0, 7, 0, 0), 0, 8, 2};
        ftab[2] = '{mk(9, 0, 3, 0, 0), 0, 8, 2};
        ftab[3] = '{mk(6, 0, 3, 0, 0), 0, 8, 2};
        ftab[4] = '{mk(0, 0, 3, 0, 0), 0, 8, 2};
        ftab[5] = '{mk(1, 0, 200, 0, 3), 0, 8, 2};
        ftab[6] = '{mk(2, 0, 3, 0, 1), 1, 8, 2};
        ftab[7] = '{64'h0, 0, 0, 2};
        gpc = '{0, 1, 2, 3, 4, 5, 2, 3, 4, 5, 2};
        for (int k = 0; k < 11; k++) gtab[k] = '{6 + 5 * k, 0, 32'h30 + 32'(gpc[k])};

        rst = 1'b0; en = 1'b0; en_g = 1'b0; bus = '0; bus_g = '0;
        step();
        step();
        chk("reset_out", 32'(out), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_gen_out", 32'(out_g), 0);
        rst = 1'b1;

        // Default program: thread 0 alternates 1, 2
        cmd(mk(1, 0, 0, 0, 1));
        cmd(mk(1, 0, 0, 1, 2));
        cmd(mk(2, 0, 0, 0, 1));
        en = 1'b1;
        for (int j = 0; j < 11; j++) dt[j] = (j < 5) ? dtab[j] : '{-1, 0, 0};
        run_table("default", dt, 5, 26);
        chk("default_done", 32'(done), 0);

        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stall_out", 32'(out), 2);
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        bus = mk(1, 0, 0, 0, 3);
        step();
        chk("resume_out", 32'(out), 1);
        chk("pending_busy", 32'(busy), 1);
        bus = '0;

        // Async reset mid-cycle with the write still in stage C
        #3 rst = 1'b0;
        #1;
        chk("async_out", 32'(out), 0);
        chk("async_done", 32'(done), 0);
        chk("async_busy", 32'(busy), 0);
        step();
        step();
        rst = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (s == 4)  chk("post_rst_lat", 32'(out), 0);
            if (s == 5)  chk("rst_cmd_dropped", 32'(out), 1);
            if (s == 12) chk("rst_max_cleared", 32'(out), 1);
        end

        en = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("oneshot_start_out", 32'(out), 0);
        cmd(mk(1, 0, 3, 0, 3));
        cmd(mk(1, 0, 3, 1, 2));
        cmd(mk(4, 0, 3, 0, 1));
        cmd(mk(2, 0, 3, 0, 1));
        en = 1'b1;
        run_table("oneshot", otab, 11, 36);

        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus = ftab[i].bus;
            step();
            chk($sformatf("filter%0d_busy", i), 32'(busy), ftab[i].busy);
            chk($sformatf("filter%0d_done", i), 32'(done), ftab[i].done);
            chk($sformatf("filter%0d_out", i), 32'(out), ftab[i].out);
        end
        bus = '0;

        // Wider instance: 5 threads, LOOP max=5 loop=2 on thread 1
        bus_g = mk(2, 0, 1, 0, 5);
        step();
        chk("gen_filter_busy", 32'(busy_g), 0);
        for (int a = 0; a < 6; a++) cmd_g(mk(1, 2, 1, a, 8'h30 + a));
        cmd_g(mk(2, 2, 1, 0, 5));
        cmd_g(mk(3, 2, 1, 0, 2));
        en_g = 1'b1;
        for (int s = 1; s <= 56; s++) begin
            step();
            for (int j = 0; j < 11; j++) begin
                if (gtab[j].step == s) chk($sformatf("gen_slot%0d", j), 32'(out_g), gtab[j].exp);
            end
        end
        chk("gen_done", 32'(done_g), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
